c432_key_loader: RTL and testbench
==================================

// Module: c432_key_loader
// PURPOSE
//   Serial key-delivery stage directly upstream of the key-locked c432 netlist.
//   - Accepts the 12-bit obfuscation key one bit per beat over a valid/ready handshake.
//   - Checks an even-parity trailer beat, then drives the key onto the netlist key inputs s_0..s_11.
//   - A zero key is driven until a frame is accepted.
//   - A saturating failure counter hard-locks the loader after repeated bad frames.
// PARAMETERS
//   KEY_W      12  key width; key_out[i] drives s_i of the locked netlist
//   CNT_W       4  beat-counter width; must hold KEY_W+1
//   MAX_FAIL    3  bad frames tolerated before permanent lockout (1..7)
// PORTS
//   clk          in   1      single clock, all state on rising edge
//   rst          in   1      synchronous, active-high reset
//   key_bit_in   in   1      serial key/parity bit
//   key_valid_in in   1      beat valid
//   key_last_in  in   1      marks parity (final) beat of a frame
//   key_ready    out  1      loader can accept a beat this cycle
//   clear_in     in   1      abandon/unload: return to IDLE, zero key
//   key_out      out  KEY_W  key to netlist (bit i -> s_i)
//   key_locked   out  1      key_out holds a parity-checked key
//   key_err      out  1      frame rejected; waiting for clear_in
//   lockout      out  1      fail count reached MAX_FAIL; only rst exits
// BEHAVIOUR
//   Reset (synchronous, active-high, one clock, reset is synchronous and active-high):
//     - state=IDLE, shift reg=0, beat count=0, fail count=0.
//     - key_out=0, key_locked=0, key_err=0, lockout=0, key_ready=1.
//   Beat accepted when key_valid_in & key_ready. Bits arrive LSB first: beat 0 -> key bit 0.
//   States:
//     IDLE   - ready=1. An accepted beat with last=0 stores bit 0, count=1 -> SHIFT.
//              An accepted beat with last=1 -> ERROR.
//     SHIFT  - ready=1. Each accepted beat stores bit[count] and increments count.
//              Beat index KEY_W (the (KEY_W+1)th beat) is the parity bit and must carry last=1.
//              If last=1 and XOR(key bits, parity)==0 -> LOCKED.
//              Parity mismatch -> ERROR.
//              last=1 on a beat index < KEY_W -> ERROR.
//              last=0 on beat index KEY_W -> ERROR (overlong frame).
//     LOCKED - ready=0. key_out=shift reg, key_locked=1; both rise the cycle after the parity beat.
//              Input beats are ignored. clear_in -> IDLE next cycle with key_out=0.
//     ERROR  - ready=0, key_err=1, key_out=0.
//              On entry, fail count increments (saturating at MAX_FAIL).
//              If the count reaches MAX_FAIL, lockout=1 and ERROR is held permanently.
//              Otherwise clear_in -> IDLE.
//   key_out never shows partial keys: it changes only on entry to or exit from LOCKED.
//   clear_in in IDLE/SHIFT: abandon the frame, count=0, shift reg=0, stay/return IDLE.
//     - No beat is consumed that cycle, even if valid & ready.
//     - Not counted as a failure.
//   clear_in and an accepted beat in the same cycle: clear wins.
//   Successful lock does not reset the fail count; only rst does.
//   Reset mid-frame or while LOCKED: full reset values above on the next edge.
//   Combinational outputs: none. All outputs are registered, except key_ready,
//     which is decoded from the state register.
// TESTING
//   1 Key 12'hA5C (popcount 6), parity 0, last on beat 12
//     -> key_locked=1 and key_out=12'hA5C one cycle after beat 12; ready=0.
//   2 Key 12'hA5C with parity 1
//     -> key_err=1, key_out=0. clear_in -> IDLE, ready=1, lockout=0.
//   3 last=1 on beat 5, then a separate 14-beat frame without last on beat 12
//     -> both frames enter ERROR; fail count reaches 2.
//   4 Three bad frames each followed by clear_in
//     -> lockout=1 after the third; clear_in ignored; rst restores IDLE.
//   5 clear_in asserted with valid beat 7 mid-frame, then a good frame 12'h001
//     -> first frame discarded; key_out=12'h001 with parity 1.
//   6 rst asserted while LOCKED with key 12'hFFF
//     -> next cycle key_out=0, key_locked=0, ready=1; beats while LOCKED had no effect.

Source files
------------

// File: rtl/c432_key_loader.sv
// c432_key_loader
//   Serial key-delivery stage in front of the key-locked c432 netlist.
//   A 12-bit key arrives LSB first, one bit per accepted beat, followed by an
//   even-parity trailer beat flagged with key_last_in. A good frame is driven
//   onto key_out (bit i -> s_i); otherwise key_out stays zero. Repeated bad
//   frames saturate a failure counter and hard-lock the loader until rst.
//
//   Handshake: a beat transfers on a rising edge where key_valid_in and
//   key_ready are both high. key_ready is decoded from the state register and
//   does not depend on key_valid_in. clear_in takes priority over a beat in
//   the same cycle, so that beat is not consumed.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   key_bit_in     serial key / parity bit
//   key_valid_in   beat valid
//   key_last_in    marks the parity (final) beat
//   key_ready      loader can accept a beat this cycle
//   clear_in       abandon a frame / unload a key / leave non-latched ERROR
//   key_out        key to the netlist (registered)
//   key_locked     key_out holds a parity-checked key (registered)
//   key_err        frame rejected, waiting for clear_in (registered)
//   lockout        failure limit reached, only rst exits (registered)
//   fsm_state      current state, for debug and checkers
module c432_key_loader #(
    parameter int KEY_W    = 12,
    parameter int CNT_W    = 4,
    parameter int MAX_FAIL = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_bit_in,
    input  logic             key_valid_in,
    input  logic             key_last_in,
    output logic             key_ready,
    input  logic             clear_in,
    output logic [KEY_W-1:0] key_out,
    output logic             key_locked,
    output logic             key_err,
    output logic             lockout,
    output logic [1:0]       fsm_state
);

    localparam int FAIL_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        LOCKED = 2'd2,
        ERROR  = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [KEY_W-1:0]  shift_reg, shift_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [FAIL_W-1:0] fail_cnt, fail_next;
    logic              lockout_next;
    logic              beat;
    logic              parity_ok;

    assign key_ready = (state == IDLE) || (state == SHIFT);
    assign fsm_state = state;
    assign beat      = key_valid_in && key_ready;
    // Even parity over the key bits plus the trailer bit.
    assign parity_ok = ((^shift_reg) ^ key_bit_in) == 1'b0;

    always_comb begin
        state_next   = state;
        shift_next   = shift_reg;
        cnt_next     = cnt;
        fail_next    = fail_cnt;
        lockout_next = lockout;

        case (state)
            IDLE, SHIFT: begin
                // cnt is zero in IDLE, so both states share the beat logic.
                if (clear_in) begin
                    state_next = IDLE;
                    shift_next = '0;
                    cnt_next   = '0;
                end else if (beat) begin
                    if (cnt == CNT_W'(KEY_W)) begin
                        state_next = (key_last_in && parity_ok) ? LOCKED : ERROR;
                    end else if (key_last_in) begin
                        state_next = ERROR;
                    end else begin
                        shift_next = shift_reg | (KEY_W'(key_bit_in) << cnt);
                        cnt_next   = cnt + CNT_W'(1);
                        state_next = SHIFT;
                    end
                end
            end
            LOCKED: begin
                if (clear_in) begin
                    state_next = IDLE;
                    shift_next = '0;
                    cnt_next   = '0;
                end
            end
            ERROR: begin
                if (clear_in && !lockout) begin
                    state_next = IDLE;
                    shift_next = '0;
                    cnt_next   = '0;
                end
            end
            default: state_next = IDLE;
        endcase

        // Failure bookkeeping happens once, on entry to ERROR.
        if (state_next == ERROR && state != ERROR) begin
            shift_next = '0;
            cnt_next   = '0;
            if (fail_cnt < FAIL_W'(MAX_FAIL)) begin
                fail_next = fail_cnt + FAIL_W'(1);
            end
            if (fail_next == FAIL_W'(MAX_FAIL)) begin
                lockout_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            cnt        <= '0;
            fail_cnt   <= '0;
            key_out    <= '0;
            key_locked <= 1'b0;
            key_err    <= 1'b0;
            lockout    <= 1'b0;
        end else begin
            state      <= state_next;
            shift_reg  <= shift_next;
            cnt        <= cnt_next;
            fail_cnt   <= fail_next;
            // shift_reg is complete when LOCKED is entered (the parity beat
            // is not stored) and frozen while LOCKED, so no partial key leaks.
            key_out    <= (state_next == LOCKED) ? shift_reg : '0;
            key_locked <= (state_next == LOCKED);
            key_err    <= (state_next == ERROR);
            lockout    <= lockout_next;
        end
    end

endmodule

// File: tb/tb_c432_key_loader.sv
// Directed testbench for c432_key_loader. Inputs change 1 ns after a rising
// edge; outputs are sampled at the same point, after the edge has settled.
module tb_c432_key_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_bit_in = 1'b0;
    logic        key_valid_in = 1'b0;
    logic        key_last_in = 1'b0;
    logic        key_ready;
    logic        clear_in = 1'b0;
    logic [11:0] key_out;
    logic        key_locked;
    logic        key_err;
    logic        lockout;
    logic [1:0]  fsm_state;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    c432_key_loader dut (
        .clk          (clk),
        .rst          (rst),
        .key_bit_in   (key_bit_in),
        .key_valid_in (key_valid_in),
        .key_last_in  (key_last_in),
        .key_ready    (key_ready),
        .clear_in     (clear_in),
        .key_out      (key_out),
        .key_locked   (key_locked),
        .key_err      (key_err),
        .lockout      (lockout),
        .fsm_state    (fsm_state)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_in = 1'b0;
        key_valid_in = 1'b0;
        key_last_in = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic beat(input logic b, input logic l);
        key_bit_in = b;
        key_last_in = l;
        key_valid_in = 1'b1;
        tick();
        key_valid_in = 1'b0;
        key_last_in = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
    endtask

    task automatic send_frame(input logic [11:0] k, input logic p);
        for (int i = 0; i < 12; i++) beat(k[i], 1'b0);
        beat(p, 1'b1);
    endtask

    // Short bad frame: last on the very first beat.
    task automatic bad_frame();
        beat(1'b1, 1'b1);
    endtask

    initial begin
        // Reset values, sampled while rst is held.
        rst = 1'b1;
        tick();
        check("rst_key_out", 16'(key_out), 16'h000);
        check("rst_locked", 16'(key_locked), 16'h0);
        check("rst_err", 16'(key_err), 16'h0);
        check("rst_lockout", 16'(lockout), 16'h0);
        check("rst_ready", 16'(key_ready), 16'h1);
        rst = 1'b0;
        tick();

        // 1: good frame A5C, parity 0.
        send_frame(12'hA5C, 1'b0);
        check("t1_locked", 16'(key_locked), 16'h1);
        check("t1_key_out", 16'(key_out), 16'hA5C);
        check("t1_ready", 16'(key_ready), 16'h0);
        beat(1'b1, 1'b1);
        beat(1'b0, 1'b0);
        check("t1_ignore_key", 16'(key_out), 16'hA5C);
        check("t1_ignore_err", 16'(key_err), 16'h0);
        pulse_clear();
        check("t1_clr_key", 16'(key_out), 16'h000);
        check("t1_clr_locked", 16'(key_locked), 16'h0);
        check("t1_clr_ready", 16'(key_ready), 16'h1);

        // 2: A5C with wrong parity.
        do_reset();
        send_frame(12'hA5C, 1'b1);
        check("t2_err", 16'(key_err), 16'h1);
        check("t2_key_out", 16'(key_out), 16'h000);
        check("t2_locked", 16'(key_locked), 16'h0);
        pulse_clear();
        check("t2_clr_ready", 16'(key_ready), 16'h1);
        check("t2_clr_err", 16'(key_err), 16'h0);
        check("t2_lockout", 16'(lockout), 16'h0);

        // 3: early last, then overlong frame; count reaches 2.
        do_reset();
        for (int i = 0; i < 5; i++) beat(1'b1, 1'b0);
        beat(1'b0, 1'b1);
        check("t3a_err", 16'(key_err), 16'h1);
        pulse_clear();
        check("t3a_ready", 16'(key_ready), 16'h1);
        for (int i = 0; i < 14; i++) beat(i[0], 1'b0);
        check("t3b_err", 16'(key_err), 16'h1);
        check("t3b_lockout", 16'(lockout), 16'h0);
        pulse_clear();
        check("t3b_ready", 16'(key_ready), 16'h1);
        // A third failure must now lock out, proving the count was 2.
        bad_frame();
        check("t3_third_lockout", 16'(lockout), 16'h1);

        // 4: three bad frames, clear ignored, rst recovers.
        do_reset();
        bad_frame();
        pulse_clear();
        bad_frame();
        check("t4_two_lockout", 16'(lockout), 16'h0);
        pulse_clear();
        bad_frame();
        check("t4_lockout", 16'(lockout), 16'h1);
        check("t4_err", 16'(key_err), 16'h1);
        pulse_clear();
        check("t4_clr_ignored_ready", 16'(key_ready), 16'h0);
        check("t4_clr_ignored_lock", 16'(lockout), 16'h1);
        do_reset();
        check("t4_rst_ready", 16'(key_ready), 16'h1);
        check("t4_rst_lockout", 16'(lockout), 16'h0);
        check("t4_rst_err", 16'(key_err), 16'h0);

        // 5: clear collides with beat 7, then good frame 001 parity 1.
        do_reset();
        for (int i = 0; i < 7; i++) beat(1'b1, 1'b0);
        clear_in = 1'b1;
        beat(1'b1, 1'b0);
        clear_in = 1'b0;
        check("t5_clr_ready", 16'(key_ready), 16'h1);
        check("t5_clr_err", 16'(key_err), 16'h0);
        send_frame(12'h001, 1'b1);
        check("t5_locked", 16'(key_locked), 16'h1);
        check("t5_key_out", 16'(key_out), 16'h001);
        check("t5_err", 16'(key_err), 16'h0);

        // 6: rst while LOCKED with FFF; beats while locked ignored.
        do_reset();
        send_frame(12'hFFF, 1'b0);
        check("t6_key_out", 16'(key_out), 16'hFFF);
        for (int i = 0; i < 4; i++) beat(1'b0, i == 3);
        check("t6_ignore_key", 16'(key_out), 16'hFFF);
        check("t6_ignore_locked", 16'(key_locked), 16'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_key", 16'(key_out), 16'h000);
        check("t6_rst_locked", 16'(key_locked), 16'h0);
        check("t6_rst_ready", 16'(key_ready), 16'h1);

        // A successful lock keeps the fail count.
        do_reset();
        bad_frame();
        pulse_clear();
        bad_frame();
        pulse_clear();
        send_frame(12'h3C3, 1'b0);
        check("t7_good_key", 16'(key_out), 16'h3C3);
        pulse_clear();
        bad_frame();
        check("t7_lockout", 16'(lockout), 16'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
